// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory port arbiter.
// Owner encodings and width defaults tied to the core-wide size macros.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = `ADDR_SIZE;
  localparam int DATA_W_DEF = `INSTR_SIZE;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_IF_RD = 2'd1,
    OWN_LS_RD = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: load/store priority, bounded fetch starvation,
// one-cycle read response routing and flush-aware fetch response dropping.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int LS_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(LS_BURST_MAX);

  owner_e     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       drop_q, drop_d;
  logic       force_if;
  logic       drop_if;

  always_comb begin
    force_if = if_req & (burst_q == BURST_MAX);
    ls_gnt   = ~reset & ls_req & ~force_if;
    if_gnt   = ~reset & if_req & ~ls_gnt;
  end

  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_be    = '1;
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    burst_d = burst_q;
    if (~if_req | if_gnt) begin
      burst_d = 4'd0;
    end else if (ls_gnt && burst_q != BURST_MAX) begin
      burst_d = burst_q + 4'd1;
    end
  end

  // Owner of next cycle's mem_rdata; stores return nothing.
  always_comb begin
    state_d = OWN_IDLE;
    if (if_gnt) begin
      state_d = OWN_IF_RD;
    end else if (ls_gnt & ~ls_we) begin
      state_d = OWN_LS_RD;
    end
  end

  // A flush kills both the response arriving now and the one issued now.
  always_comb begin
    drop_d  = if_gnt & if_flush;
    drop_if = drop_q | if_flush;
  end

  always_comb begin
    if_rdata  = mem_rdata;
    ls_rdata  = mem_rdata;
    if_rvalid = ~reset & (state_q == OWN_IF_RD) & ~drop_if;
    ls_rvalid = ~reset & (state_q == OWN_LS_RD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OWN_IDLE;
      burst_q <= 4'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      drop_q  <= drop_d;
    end
  end

endmodule
